// File: rtl/rf_writeback_arbiter_if.sv
// ----------------------------------------------------------------------------
// rf_writeback_arbiter_if
//   Bundles the two writeback requesters, the register-file write port, and
//   the decode-side scoreboard signals of rf_writeback_arbiter.
//
//   p0_*      main pipeline writeback (valid/addr/data in, ready out)
//   p1_*      M-extension writeback   (valid/addr/data in, ready out)
//   rf_*      registered register-file write port (we/addr/data)
//   mark_*    decode marks a destination register as pending
//   busy_o    pending-write scoreboard, bit n = register n outstanding
//
//   slave  : used by the arbiter
//   master : used by whatever drives the requesters / decode (e.g. a bench)
// ----------------------------------------------------------------------------
interface rf_writeback_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              p0_valid_i;
    logic              p0_ready_o;
    logic [ADDR_W-1:0] p0_addr_i;
    logic [DATA_W-1:0] p0_data_i;

    logic              p1_valid_i;
    logic              p1_ready_o;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [DATA_W-1:0] p1_data_i;

    logic              rf_we_o;
    logic [ADDR_W-1:0] rf_addr_o;
    logic [DATA_W-1:0] rf_data_o;

    logic              mark_i;
    logic [ADDR_W-1:0] mark_addr_i;
    logic [31:0]       busy_o;

    modport slave (
        input  p0_valid_i, p0_addr_i, p0_data_i,
        input  p1_valid_i, p1_addr_i, p1_data_i,
        input  mark_i, mark_addr_i,
        output p0_ready_o, p1_ready_o,
        output rf_we_o, rf_addr_o, rf_data_o,
        output busy_o
    );

    modport master (
        output p0_valid_i, p0_addr_i, p0_data_i,
        output p1_valid_i, p1_addr_i, p1_data_i,
        output mark_i, mark_addr_i,
        input  p0_ready_o, p1_ready_o,
        input  rf_we_o, rf_addr_o, rf_data_o,
        input  busy_o
    );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// rf_writeback_arbiter
//   Shares the register file's single write port between the main pipeline
//   writeback (p0) and the multi-cycle mul/div unit (p1), and keeps a
//   per-register pending-write scoreboard for decode RAW stalls.
//
//   clk       rising-edge clock
//   reset_i   asynchronous reset, active-high
//   bus       rf_writeback_arbiter_if.slave
//               p0_*/p1_* : valid/ready requesters, ready is combinational
//               rf_*      : registered write port, one cycle after the grant
//               mark_*    : sets scoreboard bit at the next edge
//               busy_o    : scoreboard, bit 0 always 0
// ----------------------------------------------------------------------------
module rf_writeback_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset_i,
    rf_writeback_arbiter_if.slave bus
);
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic              gnt0;
    logic              gnt1;
    logic              p1_force;

    logic [CNT_W-1:0]  starve_cnt_d, starve_cnt_q;
    logic              rf_we_d,      rf_we_q;
    logic [ADDR_W-1:0] rf_addr_d,    rf_addr_q;
    logic [DATA_W-1:0] rf_data_d,    rf_data_q;
    logic [31:0]       busy_d,       busy_q;

    // p0 has priority unless p1 has been refused STARVE_LIMIT cycles in a row.
    always_comb begin
        p1_force = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
        gnt1     = bus.p1_valid_i && (!bus.p0_valid_i || p1_force);
        gnt0     = bus.p0_valid_i && !gnt1;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.p1_valid_i || gnt1) begin
            starve_cnt_d = '0;
        end else if (!p1_force) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Writes to x0 complete the handshake but never raise the write enable.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (gnt1) begin
            rf_we_d   = (bus.p1_addr_i != '0);
            rf_addr_d = bus.p1_addr_i;
            rf_data_d = bus.p1_data_i;
        end else if (gnt0) begin
            rf_we_d   = (bus.p0_addr_i != '0);
            rf_addr_d = bus.p0_addr_i;
            rf_data_d = bus.p0_data_i;
        end
    end

    // Clear on the edge the register file captures the data; a mark at the
    // same edge is applied afterwards so the newer producer stays pending.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_addr_q] = 1'b0;
        end
        if (bus.mark_i && (bus.mark_addr_i != '0)) begin
            busy_d[bus.mark_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
            busy_q       <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_q    <= rf_data_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.p0_ready_o = gnt0;
    assign bus.p1_ready_o = gnt1;
    assign bus.rf_we_o    = rf_we_q;
    assign bus.rf_addr_o  = rf_addr_q;
    assign bus.rf_data_o  = rf_data_q;
    assign bus.busy_o     = busy_q;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
module tb_rf_writeback_arbiter;
    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic reset_i;

    always #5 clk = ~clk;

    rf_writeback_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_writeback_arbiter #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk    (clk),
        .reset_i(reset_i),
        .bus    (bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    wr_t               exp_q[$];
    int                m_cnt;
    logic [31:0]       m_busy;
    logic              m_pend_we;
    logic [ADDR_W-1:0] m_pend_addr;
    logic              m_last_known;
    logic [ADDR_W-1:0] m_last_addr;
    logic [DATA_W-1:0] m_last_data;

    // DUT readies as sampled in the most recent cycle
    logic obs_p0, obs_p1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt        = 0;
        m_busy       = '0;
        m_pend_we    = 1'b0;
        m_pend_addr  = '0;
        m_last_known = 1'b1;
        m_last_addr  = '0;
        m_last_data  = '0;
    endtask

    task automatic drive_idle();
        bus.p0_valid_i  = 1'b0;
        bus.p0_addr_i   = '0;
        bus.p0_data_i   = '0;
        bus.p1_valid_i  = 1'b0;
        bus.p1_addr_i   = '0;
        bus.p1_data_i   = '0;
        bus.mark_i      = 1'b0;
        bus.mark_addr_i = '0;
    endtask

    // One clock cycle: drive at negedge, check readies, advance model,
    // then check the registered port and scoreboard just after posedge.
    task automatic cycle(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                         input logic mk, input logic [ADDR_W-1:0] ma);
        logic  g0, g1;
        wr_t   w;
        @(negedge clk);
        bus.p0_valid_i  = v0;
        bus.p0_addr_i   = a0;
        bus.p0_data_i   = d0;
        bus.p1_valid_i  = v1;
        bus.p1_addr_i   = a1;
        bus.p1_data_i   = d1;
        bus.mark_i      = mk;
        bus.mark_addr_i = ma;
        #1;
        g1 = v1 && (!v0 || (m_cnt == STARVE_LIMIT));
        g0 = v0 && !g1;
        obs_p0 = bus.p0_ready_o;
        obs_p1 = bus.p1_ready_o;
        chk("p0_ready", obs_p0, g0);
        chk("p1_ready", obs_p1, g1);
        chk("one_grant", obs_p0 & obs_p1, 1'b0);

        if (m_pend_we) m_busy[m_pend_addr] = 1'b0;
        if (mk && (ma != '0)) m_busy[ma] = 1'b1;
        m_busy[0] = 1'b0;
        m_pend_we = 1'b0;
        if (g0 || g1) begin
            w.addr = g1 ? a1 : a0;
            w.data = g1 ? d1 : d0;
            if (w.addr != '0) begin
                exp_q.push_back(w);
                m_pend_we    = 1'b1;
                m_pend_addr  = w.addr;
                m_last_known = 1'b1;
                m_last_addr  = w.addr;
                m_last_data  = w.data;
            end else begin
                m_last_known = 1'b0;
            end
        end
        if (!v1 || g1) m_cnt = 0;
        else if (m_cnt < STARVE_LIMIT) m_cnt++;

        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("rf_we", bus.rf_we_o, 1'b1);
            chk("rf_addr", bus.rf_addr_o, w.addr);
            chk("rf_data", bus.rf_data_o, w.data);
        end else begin
            chk("rf_we_idle", bus.rf_we_o, 1'b0);
            if (m_last_known && !(g0 || g1)) begin
                chk("rf_addr_hold", bus.rf_addr_o, m_last_addr);
                chk("rf_data_hold", bus.rf_data_o, m_last_data);
            end
        end
        chk("busy", bus.busy_o, m_busy);
    endtask

    initial begin
        logic [ADDR_W-1:0] p1_addr;
        logic [DATA_W-1:0] p1_data;
        int                we_run;

        drive_idle();
        model_reset();
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rf_we", bus.rf_we_o, 1'b0);
        chk("rst_rf_addr", bus.rf_addr_o, '0);
        chk("rst_rf_data", bus.rf_data_o, '0);
        chk("rst_busy", bus.busy_o, '0);
        chk("rst_p0_ready", bus.p0_ready_o, 1'b0);
        chk("rst_p1_ready", bus.p1_ready_o, 1'b0);
        @(negedge clk);
        reset_i = 1'b0;

        // single requester
        cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);

        // reset in the middle of a write
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
        cycle(1'b1, 5'd9, 32'h0000_0009, 1'b0, '0, '0, 1'b0, '0);
        chk("pre_rst_we", bus.rf_we_o, 1'b1);
        chk("pre_rst_busy9", bus.busy_o[9], 1'b1);
        drive_idle();
        #1;
        reset_i = 1'b1;
        #1;
        chk("async_rst_we", bus.rf_we_o, 1'b0);
        chk("async_rst_busy", bus.busy_o, '0);
        model_reset();
        @(negedge clk);
        reset_i = 1'b0;
        cycle(1'b1, 5'd3, 32'hA5A5_0003, 1'b0, '0, '0, 1'b0, '0);

        // contention: four p0 grants then one p1 grant, repeating
        p1_addr = 5'd16;
        p1_data = 32'hB000_0000;
        for (int k = 0; k < 15; k++) begin
            cycle(1'b1, ADDR_W'(1 + (k % 8)), DATA_W'(32'hC000_0000 + k),
                  1'b1, p1_addr, p1_data, 1'b0, '0);
            chk("contend_p1_slot", obs_p1, (k % 5) == 4);
            if (obs_p1) begin
                p1_addr = p1_addr + 5'd1;
                p1_data = p1_data + 32'd1;
            end
        end
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);

        // x0 write, plus a mark of x0 in the same cycle
        cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_1234, 1'b1, 5'd0);
        chk("x0_p1_ready", obs_p1, 1'b1);
        chk("x0_we", bus.rf_we_o, 1'b0);
        chk("x0_busy0", bus.busy_o[0], 1'b0);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);

        // scoreboard: set, clear on capture edge, then set-wins collision
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        chk("sb_mark7", bus.busy_o[7], 1'b1);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        chk("sb_hold7", bus.busy_o[7], 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h7777_0001, 1'b0, '0);
        chk("sb_pre_clear7", bus.busy_o[7], 1'b1);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        chk("sb_clear7", bus.busy_o[7], 1'b0);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h7777_0002, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        chk("sb_set_wins7", bus.busy_o[7], 1'b1);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        chk("sb_still7", bus.busy_o[7], 1'b1);

        // throughput: eight back-to-back p0 writes
        we_run = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, ADDR_W'(i), DATA_W'(32'h0000_1000 + i), 1'b0, '0, '0, 1'b0, '0);
            if (bus.rf_we_o === 1'b1 && bus.rf_addr_o === ADDR_W'(i)) we_run++;
        end
        chk("tput_run", we_run, 8);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
